mux7_sel_sched: RTL and testbench

//  Round-robin scheduler that shares one mux_7 path between 7 requesters.

---
 rtl/mux7_sel_sched.sv | 173 +++++++++++++++++
 tb/tb_mux7_sel_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux7_sel_sched.sv
// mux7_sel_sched
//   Round-robin scheduler sharing one 7:1 mux path among seven requesters.
//   A select change is always followed by GUARD_CYC guard cycles before the
//   one-hot grant rises, and each tenure is capped at MAX_HOLD cycles.
//   The enable mask is only loaded while idle, so an active tenure is never
//   cut short by a topology change.
//
// Parameters
//   GUARD_CYC  guard cycles between a select change and grant (0..15)
//   MAX_HOLD   maximum consecutive grant cycles per tenure (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[6:0]   level requests, bit i is mux input i
//   cfg_mask   enable mask, bit i enables req[i]
//   cfg_valid  cfg_mask is valid; held until cfg_ready
//   cfg_ready  mask accepted on this edge (combinational, high only in IDLE)
//   sel[2:0]   mux select, always 0..6
//   grant[6:0] one-hot grant, zero outside a tenure
//   busy       scheduler not idle
module mux7_sel_sched #(
  parameter int unsigned GUARD_CYC = 1,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] req,
  input  logic [6:0] cfg_mask,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic [2:0] sel,
  output logic [6:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_LAST = (GUARD_CYC == 0) ? 4'd0 : 4'(GUARD_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD);

  state_t     state, state_nx;
  logic [6:0] mask, mask_nx;
  logic [2:0] ptr, ptr_nx;
  logic [3:0] guard_cnt, guard_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic [2:0] sel_nx;
  logic [6:0] grant_nx;
  logic       busy_nx;

  logic [6:0] elig;
  logic [2:0] win;
  logic       win_vld;
  logic       guard_done;
  logic       release_now;

  assign elig = req & mask;

  // Rotating first-set scan: candidates ptr, ptr+1 .. 6, 0 .. ptr-1.
  always_comb begin
    int unsigned idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= 7) idx = idx - 7;
      if (!win_vld && elig[idx]) begin
        win     = 3'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // The current owner is always sel; req of other sources cannot end a tenure.
  assign guard_done  = (state == GUARD) && (guard_cnt == GUARD_LAST);
  assign release_now = (state == GRANT) && (!req[sel] || (hold_cnt == HOLD_LAST));

  // State register plus registered datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask      <= 7'h7F;
      ptr       <= '0;
      guard_cnt <= '0;
      hold_cnt  <= '0;
      sel       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      mask      <= mask_nx;
      ptr       <= ptr_nx;
      guard_cnt <= guard_nx;
      hold_cnt  <= hold_nx;
      sel       <= sel_nx;
      grant     <= grant_nx;
      busy      <= busy_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (win_vld) begin
          if (GUARD_CYC == 0) state_nx = GRANT;
          else                state_nx = GUARD;
        end
      end
      GUARD: begin
        if (guard_done) state_nx = GRANT;
      end
      GRANT: begin
        if (release_now) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    mask_nx  = mask;
    ptr_nx   = ptr;
    guard_nx = guard_cnt;
    hold_nx  = hold_cnt;
    sel_nx   = sel;
    grant_nx = grant;
    busy_nx  = (state_nx != IDLE);
    case (state)
      IDLE: begin
        // Arbitration on this edge still uses the old mask.
        if (cfg_valid) mask_nx = cfg_mask;
        if (win_vld) begin
          sel_nx   = win;
          guard_nx = '0;
          if (GUARD_CYC == 0) begin
            grant_nx = 7'b1 << win;
            hold_nx  = 8'd1;
          end
        end
      end
      GUARD: begin
        if (guard_done) begin
          grant_nx = 7'b1 << sel;
          hold_nx  = 8'd1;
          guard_nx = '0;
        end else begin
          guard_nx = guard_cnt + 4'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_nx = '0;
          ptr_nx   = (sel == 3'd6) ? 3'd0 : sel + 3'd1;
        end else begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: begin
        grant_nx = '0;
      end
    endcase
  end

  assign cfg_ready = (state == IDLE);

endmodule

// File: tb/tb_mux7_sel_sched.sv
// Self-checking bench for mux7_sel_sched: directed scenarios plus a random
// run, all compared against a cycle-stepped tenure model of the scheduler.
module tb_mux7_sel_sched;

  localparam int G = 1;
  localparam int H = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] req;
  logic [6:0] cfg_mask;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] sel;
  logic [6:0] grant;
  logic       busy;

  int checks;
  int failures;

  mux7_sel_sched #(.GUARD_CYC(G), .MAX_HOLD(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cfg_mask  (cfg_mask),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .sel       (sel),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an owner (-1 when idle), guard countdown, granted flag
  int         m_owner;
  int         m_guard_left;
  int         m_held;
  int         m_ptr;
  int         m_sel;
  bit         m_granted;
  bit         m_accepted;
  logic [6:0] m_mask;

  task automatic model_reset();
    m_owner      = -1;
    m_guard_left = 0;
    m_held       = 0;
    m_ptr        = 0;
    m_sel        = 0;
    m_granted    = 1'b0;
    m_accepted   = 1'b0;
    m_mask       = 7'h7F;
  endtask

  function automatic logic [6:0] exp_grant();
    if (m_granted) return 7'(7'b1 << m_owner);
    return '0;
  endfunction

  task automatic model_step();
    logic [6:0] elig;
    int w;
    m_accepted = 1'b0;
    if (m_owner < 0) begin
      elig = req & m_mask;
      if (cfg_valid) begin
        m_mask     = cfg_mask;
        m_accepted = 1'b1;
      end
      if (elig != 0) begin
        w = -1;
        for (int k = 0; k < 7; k++)
          if (w < 0 && elig[(m_ptr + k) % 7]) w = (m_ptr + k) % 7;
        m_sel   = w;
        m_owner = w;
        if (G > 0) m_guard_left = G;
        else begin m_granted = 1'b1; m_held = 1; end
      end
    end else if (!m_granted) begin
      m_guard_left--;
      if (m_guard_left == 0) begin m_granted = 1'b1; m_held = 1; end
    end else if (!req[m_owner] || m_held == H) begin
      m_granted = 1'b0;
      m_ptr     = (m_owner + 1) % 7;
      m_owner   = -1;
    end else begin
      m_held++;
    end
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT; sample after.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = '0;
    cfg_valid = 1'b0;
    cfg_mask  = 7'h7F;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 7'h00) begin failures++; $display("FAIL reset_grant got=%h exp=00", grant); end
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    tick();
    checks++; if (busy !== 1'b0 || grant !== 7'h00) begin
      failures++; $display("FAIL reset_idle busy=%b grant=%h exp busy=0 grant=00", busy, grant);
    end
  endtask

  task automatic test_first_grant();
    do_reset();
    req = 7'h01;
    tick();
    checks++; if (sel !== 3'd0 || grant !== 7'h00 || busy !== 1'b1) begin
      failures++; $display("FAIL first_edge1 sel=%0d grant=%h busy=%b exp sel=0 grant=00 busy=1", sel, grant, busy);
    end
    tick();
    checks++; if (grant !== 7'h01 || busy !== 1'b1 || grant !== exp_grant()) begin
      failures++; $display("FAIL first_edge2 grant=%h busy=%b exp grant=01 busy=1", grant, busy);
    end
    req = 7'h00;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int order[8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    int n = 0, len = 0, gap = 0;
    logic [6:0] prev = '0;
    do_reset();
    req = 7'h7F;
    for (int cyc = 0; cyc < 80 && n < 8; cyc++) begin
      tick();
      checks++; if (grant !== exp_grant()) begin
        failures++; $display("FAIL rr_model grant=%h exp=%h", grant, exp_grant());
      end
      if (grant != 0 && prev == 0) begin
        checks++; if (sel !== 3'(order[n])) begin
          failures++; $display("FAIL rr_order got=%0d exp=%0d", sel, order[n]);
        end
        if (n > 0) begin
          checks++; if (gap != 2) begin failures++; $display("FAIL rr_gap got=%0d exp=2", gap); end
        end
        n++;
        len = 1;
      end else if (grant != 0) begin
        len++;
      end
      if (grant == 0 && prev != 0) begin
        checks++; if (len != H) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", len, H); end
        gap = 1;
      end else if (grant == 0) begin
        gap++;
      end
      prev = grant;
    end
    checks++; if (n != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", n); end
    req = 7'h00;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    int n = 0;
    int exp_sel[2] = '{6, 0};
    logic [6:0] prev = '0;
    bit seen = 1'b0;
    do_reset();
    req = 7'h20;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      tick();
      if (grant == 7'h20) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL wrap_serve5 got=%h exp=20", grant); end
    req = 7'h00;
    tick();
    tick();
    req = 7'h41;
    for (int cyc = 0; cyc < 30 && n < 2; cyc++) begin
      tick();
      checks++; if (sel > 3'd6 || grant !== exp_grant()) begin
        failures++; $display("FAIL wrap_model sel=%0d grant=%h exp grant=%h", sel, grant, exp_grant());
      end
      if (grant != 0 && prev == 0) begin
        checks++; if (sel !== 3'(exp_sel[n])) begin
          failures++; $display("FAIL wrap_order got=%0d exp=%0d", sel, exp_sel[n]);
        end
        n++;
      end
      prev = grant;
    end
    checks++; if (n != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", n); end
    req = 7'h00;
    tick();
    tick();
  endtask

  task automatic test_mask_stall();
    bit seen = 1'b0;
    bit acc = 1'b0;
    int n3 = 0;
    logic pre_ready;
    logic [6:0] pre_grant;
    do_reset();
    req = 7'h04;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      tick();
      if (grant == 7'h04) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL mask_grant2 got=%h exp=04", grant); end
    req       = 7'h0F;
    cfg_valid = 1'b1;
    cfg_mask  = 7'h08;
    checks++; if (cfg_ready !== 1'b0 || grant !== 7'h04) begin
      failures++; $display("FAIL mask_stall ready=%b grant=%h exp ready=0 grant=04", cfg_ready, grant);
    end
    for (int cyc = 0; cyc < 12 && !acc; cyc++) begin
      pre_ready = cfg_ready;
      pre_grant = grant;
      tick();
      if (m_accepted) begin
        acc = 1'b1;
        cfg_valid = 1'b0;
        checks++; if (pre_ready !== 1'b1 || pre_grant !== 7'h00) begin
          failures++; $display("FAIL mask_accept ready=%b grant=%h exp ready=1 grant=00", pre_ready, pre_grant);
        end
      end else if (pre_grant != 0) begin
        checks++; if (pre_ready !== 1'b0) begin
          failures++; $display("FAIL mask_ready_busy got=%b exp=0", pre_ready);
        end
      end
    end
    checks++; if (!acc) begin failures++; $display("FAIL mask_timeout got=0 exp=1"); cfg_valid = 1'b0; end
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      checks++; if ((grant !== 7'h00 && grant !== 7'h08) || grant !== exp_grant()) begin
        failures++; $display("FAIL mask_only3 grant=%h exp=%h", grant, exp_grant());
      end
      if (grant == 7'h08) n3++;
    end
    checks++; if (n3 == 0) begin failures++; $display("FAIL mask_src3_served got=0 exp>0"); end
    req = 7'h00;
    tick();
    tick();
  endtask

  task automatic test_guard_drop();
    do_reset();
    req = 7'h01;
    tick();
    checks++; if (grant !== 7'h00 || busy !== 1'b1) begin
      failures++; $display("FAIL gdrop_guard grant=%h busy=%b exp grant=00 busy=1", grant, busy);
    end
    req = 7'h00;
    tick();
    checks++; if (grant !== 7'h01) begin failures++; $display("FAIL gdrop_granted got=%h exp=01", grant); end
    tick();
    checks++; if (grant !== 7'h00 || busy !== 1'b0) begin
      failures++; $display("FAIL gdrop_release grant=%h busy=%b exp grant=00 busy=0", grant, busy);
    end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    do_reset();
    cfg_valid = 1'b1;
    cfg_mask  = 7'h08;
    tick();
    cfg_valid = 1'b0;
    req = 7'h08;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      tick();
      if (grant == 7'h08) seen = 1'b1;
    end
    checks++; if (!seen || sel !== 3'd3) begin
      failures++; $display("FAIL areset_setup grant=%h sel=%0d exp grant=08 sel=3", grant, sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (grant !== 7'h00 || sel !== 3'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL areset_now grant=%h sel=%0d busy=%b exp 00/0/0", grant, sel, busy);
    end
    @(negedge clk);
    req = 7'h7F;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      tick();
      if (grant != 0) seen = 1'b1;
    end
    checks++; if (!seen || grant !== 7'h01 || sel !== 3'd0) begin
      failures++; $display("FAIL areset_first grant=%h sel=%0d exp grant=01 sel=0", grant, sel);
    end
    req = 7'h00;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 7'($urandom);
      if (!cfg_valid && $urandom_range(0, 19) == 0) begin
        cfg_valid = 1'b1;
        cfg_mask  = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
      end
      tick();
      if (m_accepted) cfg_valid = 1'b0;
      checks++; if (sel !== 3'(m_sel) || grant !== exp_grant() || busy !== (m_owner >= 0)
                    || cfg_ready !== (m_owner < 0)) begin
        failures++;
        $display("FAIL rand_cyc%0d sel=%0d grant=%h busy=%b ready=%b exp sel=%0d grant=%h busy=%b ready=%b",
                 cyc, sel, grant, busy, cfg_ready, m_sel, exp_grant(), m_owner >= 0, m_owner < 0);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = '0;
    cfg_mask  = 7'h7F;
    cfg_valid = 1'b0;
    model_reset();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_wrap();
    test_mask_stall();
    test_guard_drop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
